// File: rtl/present_seq_pkg.sv
// Shared types and constants for the PRESENT-80 test sequencer.
package present_seq_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 80;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENC_RST,
        S_ENC_RUN,
        S_DEC_RST,
        S_DEC_RUN,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/present_test_sequencer_if.sv
// Sequencer <-> PRESENT core bus; master is the sequencer, slave is the core.
interface present_test_sequencer_if;
    import present_seq_pkg::*;

    logic               rst_uut;
    logic [BLOCK_W-1:0] block_i_uut;
    logic [KEY_W-1:0]   key_uut;
    logic               encdec_uut;
    logic [BLOCK_W-1:0] block_o_uut;
    logic               end_enc_uut;
    logic               end_dec_uut;

    modport master (
        output rst_uut, block_i_uut, key_uut, encdec_uut,
        input  block_o_uut, end_enc_uut, end_dec_uut
    );

    modport slave (
        input  rst_uut, block_i_uut, key_uut, encdec_uut,
        output block_o_uut, end_enc_uut, end_dec_uut
    );

endinterface

// File: rtl/present_seq_counter.sv
// Saturating up-counter with synchronous clear and enable.
module present_seq_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (en && cnt != '1)   cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/present_test_sequencer.sv
// Runs one encrypt-then-decrypt pass on a PRESENT-80 core and times each phase.
// Optional per-phase watchdog enabled by defining PRESENT_SEQ_TIMEOUT_EN.
module present_test_sequencer
    import present_seq_pkg::*;
#(
    parameter int RST_CYCLES     = 2,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               pass,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   enc_cycles,
    output logic [CNT_W-1:0]   dec_cycles,
    present_test_sequencer_if.master core
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_e         state_q, state_d;
    logic [RC_W-1:0]    rst_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] pt_q;
    logic accept, in_run, run_end, rst_last, cnt_clr, cnt_en, timeout_hit;

    assign accept   = (state_q == S_IDLE) && start;
    assign in_run   = (state_q == S_ENC_RUN) || (state_q == S_DEC_RUN);
    assign run_end  = (state_q == S_ENC_RUN) ? core.end_enc_uut : core.end_dec_uut;
    assign rst_last = (rst_cnt == RC_W'(RST_CYCLES - 1));
    assign cnt_clr  = (state_d != state_q) && (state_d == S_ENC_RST || state_d == S_DEC_RST);
    assign cnt_en   = in_run && !run_end;

`ifdef PRESENT_SEQ_TIMEOUT_EN
    // Compare wide so a narrow saturating counter cannot alias the limit.
    localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES - 1);
    assign timeout_hit = cnt_en && (64'(cnt) == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             err_timeout <= 1'b0;
        else if (accept)      err_timeout <= 1'b0;
        else if (timeout_hit) err_timeout <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    present_seq_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rst_cnt <= '0;
        end else begin
            state_q <= state_d;
            rst_cnt <= (state_d != state_q) ? '0 : rst_cnt + RC_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_ENC_RST;
            S_ENC_RST: if (rst_last) state_d = S_ENC_RUN;
            S_ENC_RUN: begin
                if (core.end_enc_uut) state_d = S_DEC_RST;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_DEC_RST: if (rst_last) state_d = S_DEC_RUN;
            S_DEC_RUN: if (core.end_dec_uut || timeout_hit) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy             <= 1'b0;
            done             <= 1'b0;
            ciphertext       <= '0;
            pass             <= 1'b0;
            enc_cycles       <= '0;
            dec_cycles       <= '0;
            pt_q             <= '0;
            core.rst_uut     <= 1'b1;
            core.block_i_uut <= '0;
            core.key_uut     <= '0;
            core.encdec_uut  <= ENC;
        end else begin
            busy         <= (state_d != S_IDLE) && (state_d != S_DONE);
            done         <= (state_d == S_DONE);
            core.rst_uut <= (state_d != S_ENC_RUN) && (state_d != S_DEC_RUN);
            if (accept) begin
                pt_q             <= plaintext;
                core.block_i_uut <= plaintext;
                core.key_uut     <= key;
                core.encdec_uut  <= ENC;
                ciphertext       <= '0;
                pass             <= 1'b0;
                enc_cycles       <= '0;
                dec_cycles       <= '0;
            end
            if (in_run && run_end) begin
                if (state_q == S_ENC_RUN) begin
                    ciphertext       <= core.block_o_uut;
                    enc_cycles       <= cnt;
                    core.block_i_uut <= core.block_o_uut;
                    core.encdec_uut  <= DEC;
                end else begin
                    dec_cycles <= cnt;
                    pass       <= (core.block_o_uut == pt_q);
                end
            end
            if (timeout_hit) begin
                pass <= 1'b0;
                if (state_q == S_ENC_RUN) enc_cycles <= CNT_W'(TIMEOUT_CYCLES);
                else                      dec_cycles <= CNT_W'(TIMEOUT_CYCLES);
            end
        end
    end

endmodule

// File: tb/tb_present_test_sequencer.sv
// Directed bench for present_test_sequencer with a table-driven behavioural PRESENT core.
module tb_present_test_sequencer;
    import present_seq_pkg::*;

    localparam int R = 2;
    localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
    localparam logic [63:0] CT_ONES = 64'h3333DCD3213210D2;
    localparam logic [63:0] ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] ONES80  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIXC    = 64'hA5A5_0F0F_3C3C_9696;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Known PRESENT-80 vectors; anything else uses an invertible stand-in.
    function automatic logic [63:0] enc_f(input logic [63:0] b, input logic [79:0] k);
        if (b == 64'h0 && k == 80'h0)      return CT_ZERO;
        if (b == ONES64 && k == ONES80)    return CT_ONES;
        return b ^ k[79:16] ^ MIXC;
    endfunction

    function automatic logic [63:0] dec_f(input logic [63:0] b, input logic [79:0] k);
        if (b == CT_ZERO && k == 80'h0)    return 64'h0;
        if (b == CT_ONES && k == ONES80)   return ONES64;
        return b ^ k[79:16] ^ MIXC;
    endfunction

    // DUT 0: default counter width
    present_test_sequencer_if bus0();
    logic        start0 = 1'b0;
    logic [63:0] pt0 = '0;
    logic [79:0] key0 = '0;
    logic        busy0, done0, pass0, err0;
    logic [63:0] ct0;
    logic [31:0] enc0, dec0;

    present_test_sequencer #(.RST_CYCLES(R), .CNT_W(32), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .plaintext(pt0), .key(key0),
        .busy(busy0), .done(done0), .ciphertext(ct0), .pass(pass0), .err_timeout(err0),
        .enc_cycles(enc0), .dec_cycles(dec0), .core(bus0.master)
    );

    // DUT 1: 4-bit counters for saturation
    present_test_sequencer_if bus1();
    logic        start1 = 1'b0;
    logic [63:0] pt1 = '0;
    logic [79:0] key1 = '0;
    logic        busy1, done1, pass1, err1;
    logic [63:0] ct1;
    logic [3:0]  enc1, dec1;

    present_test_sequencer #(.RST_CYCLES(R), .CNT_W(4), .TIMEOUT_CYCLES(1024)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .plaintext(pt1), .key(key1),
        .busy(busy1), .done(done1), .ciphertext(ct1), .pass(pass1), .err_timeout(err1),
        .enc_cycles(enc1), .dec_cycles(dec1), .core(bus1.master)
    );

    // Core models: end flag rises after lat cycles out of reset.
    int   lat0 = 31, lat1 = 0, cyc0 = 0, cyc1 = 0;
    logic flip0 = 1'b0;

    always @(posedge clk) begin
        cyc0 <= bus0.rst_uut ? 0 : (cyc0 < 1000000 ? cyc0 + 1 : cyc0);
        cyc1 <= bus1.rst_uut ? 0 : (cyc1 < 1000000 ? cyc1 + 1 : cyc1);
    end

    assign bus0.end_enc_uut = !bus0.rst_uut && !bus0.encdec_uut && (cyc0 >= lat0);
    assign bus0.end_dec_uut = !bus0.rst_uut &&  bus0.encdec_uut && (cyc0 >= lat0);
    assign bus0.block_o_uut = bus0.encdec_uut
        ? (dec_f(bus0.block_i_uut, bus0.key_uut) ^ {63'b0, flip0})
        : enc_f(bus0.block_i_uut, bus0.key_uut);

    assign bus1.end_enc_uut = !bus1.rst_uut && !bus1.encdec_uut && (cyc1 >= lat1);
    assign bus1.end_dec_uut = !bus1.rst_uut &&  bus1.encdec_uut && (cyc1 >= lat1);
    assign bus1.block_o_uut = bus1.encdec_uut ? dec_f(bus1.block_i_uut, bus1.key_uut)
                                              : enc_f(bus1.block_i_uut, bus1.key_uut);

    int   r_lat, r_busy_low;
    logic r_dec_seen;
    logic [1:0] r_after;

    // Cycle index counts the start cycle as 1; r_lat is the index of the done cycle.
    task automatic run_seq(input bit sel, input logic [63:0] p, input logic [79:0] k);
        int idx;
        @(posedge clk); #1;
        if (sel) begin start1 = 1'b1; pt1 = p; key1 = k; end
        else     begin start0 = 1'b1; pt0 = p; key0 = k; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        idx = 2; r_busy_low = 0; r_dec_seen = 1'b0;
        while (!(sel ? done1 : done0) && idx < 4000) begin
            if (!(sel ? busy1 : busy0)) r_busy_low++;
            if (sel ? bus1.encdec_uut : bus0.encdec_uut) r_dec_seen = 1'b1;
            @(posedge clk); #1;
            idx++;
        end
        r_lat = (sel ? done1 : done0) ? idx : -1;
        @(posedge clk); #1;
        r_after = sel ? {done1, busy1} : {done0, busy0};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {bus0.rst_uut, bus0.encdec_uut, busy0, done0, pass0, err0}, 6'b100000);
        chk("rst_core_data", {bus0.block_i_uut, bus0.key_uut}, 128'h0);
        chk("rst_results", {ct0, enc0, dec0}, 128'h0);
        rst = 1'b1;

        lat0 = 31;
        run_seq(1'b0, 64'h0, 80'h0);
        chk("zero_ct", ct0, CT_ZERO);
        chk("zero_pass", pass0, 1'b1);
        chk("zero_enc_cycles", enc0, 32'd31);
        chk("zero_dec_cycles", dec0, 32'd31);
        chk("zero_latency", r_lat, 1 + 2 * R + 32 + 32 + 1);
        chk("zero_busy_low_cycles", r_busy_low, 0);
        chk("zero_after_done", r_after, 2'b00);
        repeat (5) @(posedge clk);
        #1;
        chk("zero_hold_ct", ct0, CT_ZERO);

        run_seq(1'b0, ONES64, ONES80);
        chk("ones_ct", ct0, CT_ONES);
        chk("ones_pass", pass0, 1'b1);

        flip0 = 1'b1;
        run_seq(1'b0, 64'h0, 80'h0);
        chk("corrupt_pass", pass0, 1'b0);
        chk("corrupt_ct", ct0, CT_ZERO);
        flip0 = 1'b0;

        // Second start mid-ENC_RUN, then async reset in DEC_RUN.
        @(posedge clk); #1;
        start0 = 1'b1; pt0 = 64'h0123_4567_89AB_CDEF; key0 = 80'h1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (R + 4) @(posedge clk);
        #1;
        start0 = 1'b1; pt0 = ONES64; key0 = ONES80;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("ignored_start_key", bus0.key_uut, 80'h1);
        chk("ignored_start_busy", busy0, 1'b1);
        n = 0;
        while (!bus0.encdec_uut && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_enc_cycles", enc0, 32'd31);
        repeat (R + 3) @(posedge clk);
        #1;
        chk("mid_dec_block_in", bus0.block_i_uut, enc_f(64'h0123_4567_89AB_CDEF, 80'h1));
        chk("mid_dec_rst_uut", bus0.rst_uut, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_ctl", {bus0.rst_uut, bus0.encdec_uut, busy0, done0, pass0, err0}, 6'b100000);
        chk("async_rst_core_data", {bus0.block_i_uut, bus0.key_uut}, 128'h0);
        chk("async_rst_results", {ct0, enc0, dec0}, 128'h0);
        #2 rst = 1'b1;

`ifdef PRESENT_SEQ_TIMEOUT_EN
        lat0 = 100000;
        run_seq(1'b0, 64'h0, 80'h0);
        chk("timeout_err", err0, 1'b1);
        chk("timeout_enc_cycles", enc0, 32'd16);
        chk("timeout_pass", pass0, 1'b0);
        chk("timeout_latency", r_lat, 1 + R + 16 + 1);
        chk("timeout_no_decrypt", r_dec_seen, 1'b0);
        lat0 = 31;
`else
        run_seq(1'b0, 64'h0, 80'h0);
        chk("no_watchdog_err", err0, 1'b0);
        chk("no_watchdog_dec_ran", r_dec_seen, 1'b1);
`endif

        lat1 = 0;
        run_seq(1'b1, 64'h0, 80'h0);
        chk("immediate_enc_cycles", enc1, 4'd0);
        chk("immediate_dec_cycles", dec1, 4'd0);
        chk("immediate_pass", pass1, 1'b1);
        chk("immediate_latency", r_lat, 1 + 2 * R + 1 + 1 + 1);

        lat1 = 40;
        run_seq(1'b1, ONES64, ONES80);
        chk("sat_enc_cycles", enc1, 4'd15);
        chk("sat_dec_cycles", dec1, 4'd15);
        chk("sat_ct", ct1, CT_ONES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
